// File: rtl/log_pkg.sv
// ============================================================================
// Module      : log_pkg
// Description : Shared constants and types for the log word packer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package log_pkg;

    localparam int LANE_W      = 72;
    localparam int LANES       = 4;
    localparam int PACKED_W    = LANE_W * LANES;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 16;

    localparam int CRED_W      = $clog2(FIFO_DEPTH + 1);
    localparam int LANE_IDX_W  = $clog2(LANES);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_credit_counter.sv
// ============================================================================
// Module      : fifo_credit_counter
// Description : Free-slot tracker for a FIFO without a full flag; saturates
//               at DEPTH and nets out a same-cycle read and write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_credit_counter #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_credits,
    output logic         o_avail
);

    localparam logic [W-1:0] c_depth = W'(DEPTH);

    logic [W-1:0] r_credits;
    logic         w_inc;

    // A read with every slot already free means the FIFO is empty: drop it.
    assign w_inc   = i_inc && (r_credits != c_depth);
    assign o_avail = (r_credits != '0) || i_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= c_depth;
        end else if (w_inc && !i_dec) begin
            r_credits <= r_credits + 1'b1;
        end else if (!w_inc && i_dec) begin
            r_credits <= r_credits - 1'b1;
        end
    end

    assign o_credits = r_credits;

endmodule

`default_nettype wire

// File: rtl/log_word_packer.sv
// ============================================================================
// Module      : log_word_packer
// Description : Packs LANES log entries into one FIFO word, credit-gated.
//               Optional idle flush: define PACKER_TIMEOUT_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_word_packer
    import log_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANE_W-1:0]     in_data,
    input  logic                  in_last,
    input  logic                  fifo_rd,
    output logic                  write_en,
    output logic [PACKED_W-1:0]   write_dt,
    output logic [CRED_W-1:0]     credits,
    output logic [LANE_IDX_W-1:0] d_lane
);

    localparam logic [LANE_IDX_W-1:0] c_last_lane = LANE_IDX_W'(LANES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PACKED_W-1:0]   r_acc;
    logic [PACKED_W-1:0]   w_word;
    logic [LANE_IDX_W-1:0] r_lane;
    logic                  w_xfer;
    logic                  w_complete;
    logic                  w_issue;
    logic                  w_avail;
    logic                  w_timeout;
    logic                  r_write_en;
    logic [PACKED_W-1:0]   r_write_dt;

    assign in_ready = (r_state == FILL);
    assign w_xfer   = in_valid && in_ready;

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int c_idle_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_idle_w-1:0] r_idle;
    logic                w_idle;

    assign w_idle    = (r_state == FILL) && (r_lane != '0) && !w_xfer;
    assign w_timeout = w_idle && (r_idle == c_idle_w'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (!w_idle || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    fifo_credit_counter #(
        .DEPTH (FIFO_DEPTH),
        .W     (CRED_W)
    ) u_credits (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (fifo_rd),
        .i_dec     (w_issue),
        .o_credits (credits),
        .o_avail   (w_avail)
    );

    always_comb begin
        w_word      = r_acc;
        w_complete  = 1'b0;
        w_issue     = 1'b0;
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_word[r_lane*LANE_W +: LANE_W] = in_data;
        end
        case (r_state)
            FILL: begin
                w_complete = (w_xfer && ((r_lane == c_last_lane) || in_last)) || w_timeout;
                w_issue    = w_complete && w_avail;
                if (w_complete && !w_avail) begin
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                w_issue = w_avail;
                if (w_avail) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A word held in PEND keeps the lane index it had after its last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_lane     <= '0;
            r_write_en <= 1'b0;
            r_write_dt <= '0;
        end else begin
            r_write_en <= w_issue;
            if (w_issue) begin
                r_write_dt <= w_word;
                r_acc      <= '0;
                r_lane     <= '0;
            end else begin
                r_acc <= w_word;
                if (w_xfer) begin
                    r_lane <= (r_lane == c_last_lane) ? '0 : r_lane + 1'b1;
                end
            end
        end
    end

    assign write_en = r_write_en;
    assign write_dt = r_write_dt;
    assign d_lane   = r_lane;

endmodule

`default_nettype wire

// File: tb/tb_log_word_packer.sv
// ============================================================================
// Module      : tb_log_word_packer
// Description : Directed plus random stimulus against a list-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_log_word_packer;
    import log_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANE_W-1:0]     in_data;
    logic                  in_last;
    logic                  fifo_rd;
    logic                  write_en;
    logic [PACKED_W-1:0]   write_dt;
    logic [CRED_W-1:0]     credits;
    logic [LANE_IDX_W-1:0] d_lane;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: entries gathered in a list, a held word, a credit count.
    logic [LANE_W-1:0]   m_cur[$];
    logic                m_pending;
    logic [PACKED_W-1:0] m_pend_word;
    int                  m_credits;
    int                  m_idle;
    logic                m_we;
    logic [PACKED_W-1:0] m_dt;

    always #5 clk = ~clk;

    log_word_packer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .fifo_rd  (fifo_rd),
        .write_en (write_en),
        .write_dt (write_dt),
        .credits  (credits),
        .d_lane   (d_lane)
    );

    task automatic chk(input string tag, input logic [PACKED_W-1:0] obs, input logic [PACKED_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PACKED_W-1:0] pack(input logic [LANE_W-1:0] ent[$]);
        logic [PACKED_W-1:0] w = '0;
        foreach (ent[k]) w[k*LANE_W +: LANE_W] = ent[k];
        return w;
    endfunction

    task automatic model_reset();
        m_cur.delete();
        m_pending = 1'b0;
        m_pend_word = '0;
        m_credits = FIFO_DEPTH;
        m_idle = 0;
        m_we = 1'b0;
        m_dt = '0;
    endtask

    // Advance the model by one clock edge given the inputs present before it.
    task automatic model_edge(input logic v, input logic [LANE_W-1:0] d, input logic l, input logic rd);
        int eff = m_credits + (rd ? 1 : 0);
        logic issue = 1'b0;
        logic done = 1'b0;
        logic [PACKED_W-1:0] word = '0;
        if (m_pending) begin
            if (eff > 0) begin
                issue = 1'b1;
                word = m_pend_word;
                m_pending = 1'b0;
            end
        end else if (v) begin
            m_cur.push_back(d);
            m_idle = 0;
            done = (m_cur.size() == LANES) || l;
        end else if (m_cur.size() > 0) begin
`ifdef PACKER_TIMEOUT_FLUSH_EN
            m_idle++;
            done = (m_idle == TIMEOUT_CYC);
`endif
        end
        if (done) begin
            word = pack(m_cur);
            m_cur.delete();
            m_idle = 0;
            if (eff > 0) begin
                issue = 1'b1;
            end else begin
                m_pending = 1'b1;
                m_pend_word = word;
            end
        end
        m_credits = m_credits + ((rd && m_credits < FIFO_DEPTH) ? 1 : 0) - (issue ? 1 : 0);
        m_we = issue;
        if (issue) m_dt = word;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, PACKED_W'(in_ready), PACKED_W'(!m_pending));
        chk({tag, ".write_en"}, PACKED_W'(write_en), PACKED_W'(m_we));
        chk({tag, ".write_dt"}, write_dt, m_dt);
        chk({tag, ".credits"},  PACKED_W'(credits), PACKED_W'(m_credits));
        if (!m_pending) chk({tag, ".d_lane"}, PACKED_W'(d_lane), PACKED_W'(m_cur.size() % LANES));
    endtask

    task automatic step(input string tag, input logic v, input logic [LANE_W-1:0] d,
                        input logic l, input logic rd);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        fifo_rd  = rd;
        model_edge(v && !m_pending, d, l, rd);
        @(posedge clk);
        #1;
        check_all(tag);
        in_valid = 1'b0;
        in_last  = 1'b0;
        fifo_rd  = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    function automatic logic [LANE_W-1:0] rnd72();
        return {$urandom_range(0, 255), $urandom, $urandom};
    endfunction

    initial begin
        logic [PACKED_W-1:0] exp_word;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        fifo_rd = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Four entries form one word; write appears one cycle after the last.
        step("w0", 1, 72'd10, 0, 0);
        step("w1", 1, 72'd30, 0, 0);
        step("w2", 1, 72'd0,  0, 0);
        step("w3", 1, 72'd99, 0, 0);
        exp_word = {72'd99, 72'd0, 72'd30, 72'd10};
        chk("first_word", write_dt, exp_word);
        chk("first_credits", PACKED_W'(credits), PACKED_W'(3));
        step("ret", 0, '0, 0, 1);

        // Exhaust credits, then a fifth word stalls in PEND.
        for (int i = 0; i < 20; i++) step("burst", 1, rnd72(), 0, 0);
        chk("pend_ready", PACKED_W'(in_ready), PACKED_W'(0));
        for (int i = 0; i < 3; i++) step("stall", 1, rnd72(), 0, 0);
        step("pend_rd", 0, '0, 0, 1);
        chk("pend_rd_credits", PACKED_W'(credits), PACKED_W'(0));

        // Completion and read at the same edge with zero credits.
        for (int i = 0; i < 3; i++) step("same", 1, rnd72(), 0, 0);
        step("same_rd", 1, rnd72(), 0, 1);
        chk("same_credits", PACKED_W'(credits), PACKED_W'(0));
        for (int i = 0; i < 5; i++) step("drain", 0, '0, 0, 1);
        chk("sat_credits", PACKED_W'(credits), PACKED_W'(FIFO_DEPTH));

        // Partial word closed by in_last at lane 0.
        step("last0", 1, 72'h5, 1, 0);
        chk("last0_dt", write_dt, PACKED_W'(72'h5));
        chk("last0_lane", PACKED_W'(d_lane), PACKED_W'(0));

        // Reset while a word is pending and d_lane is 2.
        for (int i = 0; i < 12; i++) step("fill", 1, rnd72(), 0, 0);
        step("p0", 1, rnd72(), 0, 0);
        step("p1", 1, rnd72(), 1, 0);
        chk("pre_rst_lane", PACKED_W'(d_lane), PACKED_W'(2));
        async_reset("midrst");
        for (int i = 0; i < 4; i++) step("clean", 1, rnd72(), 0, 0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step("rand", $urandom_range(0, 3) != 0, rnd72(),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
        end

        // Two entries then idle: flush only when the timeout feature is built.
        async_reset("rst2");
        step("t0", 1, rnd72(), 0, 0);
        step("t1", 1, rnd72(), 0, 0);
        for (int i = 0; i < TIMEOUT_CYC + 4; i++) step("idle", 0, '0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
